spi_arith_sequencer: RTL
========================

# spi_arith_sequencer

Parametrised control sequencer for the SPI arithmetic peripheral. It shifts N_OPS operands of OP_W bits in from the SPI shift registers, issues a one-cycle start to the arithmetic core and waits for done with a timeout. It then parallel-loads the result and shifts RES_W bits out through the MISO buffer. It replaces the fixed two-operand multiplier FSM and adds operand count, widths, a done timeout, abort on chip-select loss and a synchronous reset.

## Interface
- OP_W, 8, bits per operand shifted in.
- N_OPS, 2, operands per transaction (≥1).
- RES_W, 16, result bits shifted out (≥1).
- DONE_TIMEOUT, 64, max WAIT_DONE cycles before abort (≥2).
- sclk  in  1  single clock; all logic on posedge sclk.
- reset  in  1  synchronous, active-high.
- cs  in  1  chip select, active-high; sampled on posedge sclk.
- done  in  1  core completion level; sampled only in WAIT_DONE.
- mode  out  2  shift-register mode to operand/result registers.
- op_sel  out  $clog2(N_OPS) (min 1)  index of operand register being loaded.
- start  out  1  one-cycle core start pulse.
- misobuf_en  out  1  MISO buffer drive enable.
- busy  out  1  high in every state except IDLE.
- abort  out  1  one-cycle pulse on cs-loss or timeout.
- timeout_err  out  1  sticky; set on timeout, cleared on next accepted cs in IDLE.
- state  out  3  current state, for debug.

## Operation
- States: IDLE, LOAD, START, WAIT_DONE, CAPTURE, SHIFT_OUT.
- All outputs registered or decoded from registered state only; no latches, no negedge logic.
- Reset (any state): state=IDLE, mode=HOLD, op_sel=0, start=0, misobuf_en=0, busy=0, abort=0, timeout_err=0, counters=0.
- IDLE: mode=HOLD. cs=1 → LOAD, bit_cnt=0, op_sel=0, timeout_err cleared.
- LOAD: mode=LEFT, one bit per cycle. When bit_cnt=OP_W-1: if op_sel=N_OPS-1 → START, otherwise op_sel+1 and bit_cnt=0. Total LOAD cycles: OP_W·N_OPS.
- START: start=1, mode=HOLD, exactly one cycle → WAIT_DONE, timer=0.
- WAIT_DONE: mode=HOLD.
  - done=1 → CAPTURE.
  - Otherwise timer+1. If timer=DONE_TIMEOUT-1 with done=0 → IDLE, abort pulse, timeout_err=1.
- CAPTURE: mode=PLOAD, misobuf_en=1, one cycle → SHIFT_OUT, bit_cnt=0.
- SHIFT_OUT: mode=LEFT, misobuf_en=1. When bit_cnt=RES_W-1 → IDLE.
- cs=0 sampled in LOAD or SHIFT_OUT → IDLE next cycle, abort pulse, mode=HOLD. cs is ignored in START, WAIT_DONE and CAPTURE.
- done outside WAIT_DONE is ignored; a done held high into WAIT_DONE is accepted on the first WAIT_DONE cycle.
- Simultaneous events:
  - reset beats everything.
  - cs-loss beats counter completion in LOAD/SHIFT_OUT.
  - done beats timeout on the final WAIT_DONE cycle.
- Counters are sized to hold max(OP_W, RES_W)-1 and DONE_TIMEOUT-1. No wrap-around occurs in normal flow.

## Timing
- cs sampled high at edge k → LOAD from edge k; first shift at edge k+1.
- start asserts for the cycle following the last LOAD cycle.
- done sampled at edge j → CAPTURE from edge j.
- misobuf_en is high for RES_W+1 cycles (CAPTURE + SHIFT_OUT).
- abort is high for exactly the first cycle back in IDLE after an abort event.
- Minimum transaction length: OP_W·N_OPS + 1 + 1 + 1 + RES_W cycles from the cs-sampling edge.

## Structure
- Shared package spi_seq_pkg holds:
  - state encodings: IDLE=0, LOAD=1, START=2, WAIT_DONE=3, CAPTURE=4, SHIFT_OUT=5.
  - shift-register mode codes: HOLD=2'd0, RIGHT=2'd1, LEFT=2'd2, PLOAD=2'd3. These are shared with the operand/result shift registers.
- One sub-module: seq_counter, a parametrised up-counter with synchronous clear and enable and a terminal-value compare. It is instantiated twice, once for bit_cnt and once for timer.

## Test plan
- Full transaction (OP_W=8, N_OPS=2, RES_W=16): cs=1 held; done raised 5 cycles after start.
  - Expect 16 LEFT cycles, op_sel 0 then 1 (8 cycles each).
  - Expect start high for exactly 1 cycle, then PLOAD for 1 cycle.
  - Expect 16 LEFT cycles with misobuf_en=1, then IDLE with busy=0.
- cs dropped on LOAD cycle 5: IDLE next cycle, abort=1 for 1 cycle, start never asserted, mode=HOLD.
- done never asserted: exactly 64 WAIT_DONE cycles, then IDLE, abort pulse and timeout_err=1. The next cs=1 clears timeout_err.
- done pulsed during LOAD and held high before START: the LOAD pulse is ignored; with done still high, CAPTURE follows on the first WAIT_DONE cycle.
- reset asserted on SHIFT_OUT cycle 7: next cycle every output equals its reset value. A new cs then starts a clean transaction.
- Parameter sweep OP_W=4, N_OPS=3, RES_W=12: op_sel steps 0→1→2 every 4 cycles, LOAD lasts 12 cycles and SHIFT_OUT lasts 12 cycles.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared encodings for the SPI arithmetic sequencer and its shift registers.
// The mode codes are also decoded by the operand/result shift registers.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_SHIFT_OUT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_RIGHT = 2'd1,
    MODE_LEFT  = 2'd2,
    MODE_PLOAD = 2'd3
  } mode_t;

  // Bits needed to index 0..value-1, never less than one bit.
  function automatic int clog2Min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_arith_sequencer_seq_counter.sv
// Up-counter with synchronous clear/enable and a compare against a terminal value.
// Clear has priority over enable.
module seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_atTerm
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_atTerm = (r_count == i_term);

endmodule

// File: rtl/spi_arith_sequencer.sv
// Control sequencer: shifts operands in, starts the core, waits for done with a
// timeout, then parallel-loads the result and shifts it out through MISO.
module spi_arith_sequencer
  import spi_seq_pkg::*;
#(
  parameter int OP_W         = 8,
  parameter int N_OPS        = 2,
  parameter int RES_W        = 16,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                          sclk,
  input  logic                          reset,
  input  logic                          cs,
  input  logic                          done,
  output logic [1:0]                    mode,
  output logic [clog2Min1(N_OPS)-1:0]   op_sel,
  output logic                          start,
  output logic                          misobuf_en,
  output logic                          busy,
  output logic                          abort,
  output logic                          timeout_err,
  output logic [2:0]                    state
);

  localparam int OPS_W = clog2Min1(N_OPS);
  localparam int CNT_W = clog2Min1(maxOf(OP_W, RES_W));
  localparam int TMR_W = clog2Min1(DONE_TIMEOUT);

  localparam logic [OPS_W-1:0] LAST_OP       = OPS_W'(N_OPS - 1);
  localparam logic [CNT_W-1:0] OP_LAST_BIT   = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] RES_LAST_BIT  = CNT_W'(RES_W - 1);
  localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(DONE_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [OPS_W-1:0] r_opSel;
  logic [OPS_W-1:0] w_nextOpSel;
  logic             r_abort;
  logic             w_nextAbort;
  logic             r_timeoutErr;
  logic             w_nextTimeoutErr;
  logic             w_bitClr;
  logic             w_bitEn;
  logic             w_bitTerm;
  logic [CNT_W-1:0] w_bitLast;
  logic             w_tmrClr;
  logic             w_tmrEn;
  logic             w_tmrTerm;

  // The bit counter is shared by LOAD and SHIFT_OUT, so its terminal follows the state.
  assign w_bitLast = (r_state == ST_SHIFT_OUT) ? RES_LAST_BIT : OP_LAST_BIT;

  seq_counter #(.WIDTH(CNT_W)) u_bitCnt (
    .i_clk    (sclk),
    .i_reset  (reset),
    .i_clr    (w_bitClr),
    .i_en     (w_bitEn),
    .i_term   (w_bitLast),
    .o_atTerm (w_bitTerm)
  );

  seq_counter #(.WIDTH(TMR_W)) u_timer (
    .i_clk    (sclk),
    .i_reset  (reset),
    .i_clr    (w_tmrClr),
    .i_en     (w_tmrEn),
    .i_term   (TMR_LAST),
    .o_atTerm (w_tmrTerm)
  );

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_opSel      <= '0;
      r_abort      <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_opSel      <= w_nextOpSel;
      r_abort      <= w_nextAbort;
      r_timeoutErr <= w_nextTimeoutErr;
    end
  end

  // cs-loss is tested before counter completion; done before the timeout.
  always_comb begin
    w_nextState      = r_state;
    w_nextOpSel      = r_opSel;
    w_nextAbort      = 1'b0;
    w_nextTimeoutErr = r_timeoutErr;
    w_bitClr         = 1'b0;
    w_bitEn          = 1'b0;
    w_tmrClr         = 1'b1;
    w_tmrEn          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_bitClr = 1'b1;
        if (cs) begin
          w_nextState      = ST_LOAD;
          w_nextOpSel      = '0;
          w_nextTimeoutErr = 1'b0;
        end
      end
      ST_LOAD: begin
        if (!cs) begin
          w_nextState = ST_IDLE;
          w_nextAbort = 1'b1;
          w_bitClr    = 1'b1;
        end else if (w_bitTerm) begin
          w_bitClr = 1'b1;
          if (r_opSel == LAST_OP) begin
            w_nextState = ST_START;
          end else begin
            w_nextOpSel = r_opSel + OPS_W'(1);
          end
        end else begin
          w_bitEn = 1'b1;
        end
      end
      ST_START: begin
        w_nextState = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        w_tmrClr = 1'b0;
        if (done) begin
          w_nextState = ST_CAPTURE;
        end else if (w_tmrTerm) begin
          w_nextState      = ST_IDLE;
          w_nextAbort      = 1'b1;
          w_nextTimeoutErr = 1'b1;
        end else begin
          w_tmrEn = 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_bitClr    = 1'b1;
        w_nextState = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        if (!cs) begin
          w_nextState = ST_IDLE;
          w_nextAbort = 1'b1;
          w_bitClr    = 1'b1;
        end else if (w_bitTerm) begin
          w_nextState = ST_IDLE;
          w_bitClr    = 1'b1;
        end else begin
          w_bitEn = 1'b1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mode       = MODE_HOLD;
    start      = 1'b0;
    misobuf_en = 1'b0;
    case (r_state)
      ST_LOAD:      mode = MODE_LEFT;
      ST_START:     start = 1'b1;
      ST_CAPTURE: begin
        mode       = MODE_PLOAD;
        misobuf_en = 1'b1;
      end
      ST_SHIFT_OUT: begin
        mode       = MODE_LEFT;
        misobuf_en = 1'b1;
      end
      default: mode = MODE_HOLD;
    endcase
  end

  assign busy        = (r_state != ST_IDLE);
  assign op_sel      = r_opSel;
  assign abort       = r_abort;
  assign timeout_err = r_timeoutErr;
  assign state       = r_state;

endmodule
